pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RV32 pipeline (F, D, E, M, W).
- Generates per-stage stall/flush vectors and E-stage operand forwarding selects.
- Launches and waits on the multi-cycle multiplier; holds the pipeline during data-memory wait states.
- Sits beside the pipeline register bank; its outputs drive the stage stall/flush arrays and the r1/r2 E-stage muxes.

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle between the RV32 pipeline register bank and pipeline_ctrl.
// master = the controller side (drives stall/flush/selects), slave = the pipeline side.
interface pipeline_ctrl_if #(
  parameter int N_STAGES = 5,
  parameter int CNT_W    = 32
);
  logic [4:0]          rs1_d;
  logic [4:0]          rs2_d;
  logic [4:0]          rs1_e;
  logic [4:0]          rs2_e;
  logic [4:0]          rd_e;
  logic [4:0]          rd_m;
  logic [4:0]          rd_w;
  logic                we_e;
  logic                we_m;
  logic                we_w;
  logic                load_e;
  logic                branch_hit;
  logic                mul_start_e;
  logic                mul_busy;
  logic                dmem_req_m;
  logic                dmem_ack;
  logic [N_STAGES-1:0] stall;
  logic [N_STAGES-1:0] flush;
  logic [1:0]          r1_e_sel;
  logic [1:0]          r2_e_sel;
  logic                mul_go;
  logic                mul_timeout;
  logic [CNT_W-1:0]    stall_cycles;
  logic [CNT_W-1:0]    flush_events;

  modport master (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  we_e, we_m, we_w, load_e, branch_hit, mul_start_e, mul_busy,
    input  dmem_req_m, dmem_ack,
    output stall, flush, r1_e_sel, r2_e_sel, mul_go, mul_timeout,
    output stall_cycles, flush_events
  );

  modport slave (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output we_e, we_m, we_w, load_e, branch_hit, mul_start_e, mul_busy,
    output dmem_req_m, dmem_ack,
    input  stall, flush, r1_e_sel, r2_e_sel, mul_go, mul_timeout,
    input  stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline (F D E M W).
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; launches multiplies, handles branch/load-use
// MUL_WAIT | multiply in flight; F/D/E held, watchdog counting down
// MUL_HOLD | multiply done but M is waiting on memory; no relaunch
module pipeline_ctrl #(
  parameter int N_STAGES    = 5,
  parameter int MUL_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.master bus
);

  localparam int WD_W = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MUL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_HOLD = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WD_W-1:0]     wd_cnt;
  logic                mul_timeout_q;
  logic                mem_hold;
  logic                load_hit;
  logic                load_use;
  logic                launch;
  logic                abort;
  logic [N_STAGES-1:0] stall_raw;
  logic [N_STAGES-1:0] flush_raw;
  logic [N_STAGES-1:0] stall_o;
  logic [N_STAGES-1:0] flush_o;
  logic                unused_we_e;

  assign unused_we_e = bus.we_e;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (rs == 5'd0)                 return 2'd0;
    else if (we_m && (rd_m == rs))  return 2'd1;
    else if (we_w && (rd_w == rs))  return 2'd2;
    else                            return 2'd0;
  endfunction

  assign mem_hold = bus.dmem_req_m && !bus.dmem_ack;
  assign load_hit = bus.load_e && (bus.rd_e != 5'd0) &&
                    ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  always_comb begin
    stall_raw = '0;
    flush_raw = '0;
    state_nxt = state;
    launch    = 1'b0;
    abort     = 1'b0;
    load_use  = 1'b0;

    case (state)
      RUN: begin
        if (bus.mul_start_e) begin
          if (!mem_hold) begin
            launch         = 1'b1;
            stall_raw[2:0] = 3'b111;
            flush_raw[3]   = 1'b1;
            state_nxt      = MUL_WAIT;
          end
        end else if (bus.branch_hit) begin
          flush_raw[2:1] = 2'b11;
        end else if (load_hit) begin
          load_use       = 1'b1;
          stall_raw[1:0] = 2'b11;
          flush_raw[2]   = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (bus.mul_busy) begin
          // Watchdog expiry: drop the multiply out of E and go back to issuing.
          if (wd_cnt == '0) begin
            abort          = 1'b1;
            stall_raw[1:0] = 2'b11;
            flush_raw[2]   = 1'b1;
            state_nxt      = RUN;
          end else begin
            stall_raw[2:0] = 3'b111;
            flush_raw[3]   = 1'b1;
          end
        end else begin
          state_nxt = mem_hold ? MUL_HOLD : RUN;
        end
      end
      MUL_HOLD: begin
        if (!mem_hold) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    if (mem_hold) begin
      stall_raw      = '0;
      stall_raw[3:0] = 4'b1111;
      flush_raw      = '0;
      flush_raw[4]   = 1'b1;
      load_use       = 1'b0;
    end
  end

  always_comb begin
    if (rst) begin
      stall_o      = '0;
      flush_o      = '1;
      bus.r1_e_sel = 2'd0;
      bus.r2_e_sel = 2'd0;
      bus.mul_go   = 1'b0;
    end else begin
      stall_o      = stall_raw & ~flush_raw;
      flush_o      = flush_raw;
      bus.r1_e_sel = fwd_sel(bus.rs1_e, bus.we_m, bus.rd_m, bus.we_w, bus.rd_w);
      bus.r2_e_sel = fwd_sel(bus.rs2_e, bus.we_m, bus.rd_m, bus.we_w, bus.rd_w);
      bus.mul_go   = launch;
    end
  end

  assign bus.stall       = stall_o;
  assign bus.flush       = flush_o;
  assign bus.mul_timeout = mul_timeout_q;

  // Watchdog is a down-counter; WD_LOAD is its cleared value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wd_cnt        <= WD_LOAD;
      mul_timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch)
        wd_cnt <= WD_LOAD;
      else if ((state == MUL_WAIT) && bus.mul_busy && (wd_cnt != '0))
        wd_cnt <= wd_cnt - 1'b1;
      if (abort)
        mul_timeout_q <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o[0] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((flush_o[1] || load_use) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_events = flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding, load-use, multiply, watchdog,
// memory hold and reset, with hand-computed expectations.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipeline_ctrl_if #(.N_STAGES(5), .CNT_W(32)) bus ();

  pipeline_ctrl #(.N_STAGES(5), .MUL_TIMEOUT(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rs1_e = 0; bus.rs2_e = 0;
    bus.rd_e = 0; bus.rd_m = 0; bus.rd_w = 0;
    bus.we_e = 0; bus.we_m = 0; bus.we_w = 0;
    bus.load_e = 0; bus.branch_hit = 0; bus.mul_start_e = 0; bus.mul_busy = 0;
    bus.dmem_req_m = 0; bus.dmem_ack = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_in();
    rst = 1'b1;
    bus.rs1_e = 5; bus.we_m = 1; bus.rd_m = 5; bus.mul_start_e = 1;
    tick();
    #1;
    chk("rst_stall",   bus.stall,        32'h00);
    chk("rst_flush",   bus.flush,        32'h1f);
    chk("rst_sel1",    bus.r1_e_sel,     32'd0);
    chk("rst_mul_go",  bus.mul_go,       32'd0);
    chk("rst_timeout", bus.mul_timeout,  32'd0);
    chk("rst_scnt",    bus.stall_cycles, 32'd0);
    chk("rst_fcnt",    bus.flush_events, 32'd0);

    clear_in();
    rst = 1'b0;
    tick();
    #1;
    chk("idle_stall", bus.stall, 32'h00);
    chk("idle_flush", bus.flush, 32'h00);

    // forwarding
    bus.rs1_e = 5; bus.we_m = 1; bus.rd_m = 5; bus.we_w = 1; bus.rd_w = 5; bus.rs2_e = 9;
    #1;
    chk("fwd_m_prio", bus.r1_e_sel, 32'd1);
    chk("fwd_r2_none", bus.r2_e_sel, 32'd0);
    bus.we_m = 0;
    #1;
    chk("fwd_w", bus.r1_e_sel, 32'd2);
    bus.we_m = 1; bus.rs1_e = 0; bus.rd_m = 0; bus.rd_w = 0;
    #1;
    chk("fwd_x0", bus.r1_e_sel, 32'd0);
    bus.rs2_e = 9; bus.rd_m = 9; bus.we_w = 0;
    #1;
    chk("fwd_r2_m", bus.r2_e_sel, 32'd1);

    // load-use
    clear_in();
    bus.load_e = 1; bus.rd_e = 7; bus.rs2_d = 7;
    #1;
    chk("lu_stall", bus.stall, 32'h03);
    chk("lu_flush", bus.flush, 32'h04);
    tick();
    bus.load_e = 0;
    #1;
    chk("lu_after_stall", bus.stall, 32'h00);
    chk("lu_after_flush", bus.flush, 32'h00);
    bus.load_e = 1; bus.branch_hit = 1;
    #1;
    chk("lu_br_flush", bus.flush, 32'h06);
    chk("lu_br_stall", bus.stall, 32'h00);
    tick();
    clear_in();
    bus.load_e = 1; bus.rd_e = 0; bus.rs1_d = 0;
    #1;
    chk("lu_x0_stall", bus.stall, 32'h00);
    tick();
    clear_in();

    // multiply: launch + 4 busy cycles stalled, then release
    bus.mul_start_e = 1;
    #1;
    chk("mul_go_launch", bus.mul_go, 32'd1);
    chk("mul_launch_stall", bus.stall, 32'h07);
    chk("mul_launch_flush", bus.flush, 32'h08);
    tick();
    bus.mul_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mul_wait_go", bus.mul_go, 32'd0);
      chk("mul_wait_stall", bus.stall, 32'h07);
      chk("mul_wait_flush", bus.flush, 32'h08);
      tick();
    end
    bus.mul_busy = 0;
    #1;
    chk("mul_rel_stall", bus.stall, 32'h00);
    chk("mul_rel_go", bus.mul_go, 32'd0);
    tick();
    clear_in();
    bus.load_e = 1; bus.rd_e = 3; bus.rs1_d = 3;
    #1;
    chk("mul_back_run", bus.stall, 32'h03);
    tick();
    clear_in();

    // memory hold during MUL_WAIT while the multiplier finishes
    bus.mul_start_e = 1;
    #1;
    chk("mh_go", bus.mul_go, 32'd1);
    tick();
    bus.mul_busy = 1; bus.dmem_req_m = 1; bus.dmem_ack = 0;
    #1;
    chk("mh_wait_stall", bus.stall, 32'h0f);
    chk("mh_wait_flush", bus.flush, 32'h10);
    tick();
    bus.mul_busy = 0;
    #1;
    chk("mh_fall_stall", bus.stall, 32'h0f);
    chk("mh_fall_go", bus.mul_go, 32'd0);
    tick();
    #1;
    chk("mh_hold_stall", bus.stall, 32'h0f);
    chk("mh_hold_go", bus.mul_go, 32'd0);
    tick();
    bus.dmem_ack = 1;
    #1;
    chk("mh_ack_stall", bus.stall, 32'h00);
    chk("mh_ack_go", bus.mul_go, 32'd0);
    tick();
    clear_in();
    bus.load_e = 1; bus.rd_e = 4; bus.rs2_d = 4;
    #1;
    chk("mh_back_run", bus.stall, 32'h03);
    tick();
    clear_in();

    // memory hold in RUN defers the launch
    bus.mul_start_e = 1; bus.dmem_req_m = 1;
    #1;
    chk("mh_run_nogo", bus.mul_go, 32'd0);
    chk("mh_run_stall", bus.stall, 32'h0f);
    tick();
    bus.dmem_ack = 1;
    #1;
    chk("mh_run_retry_go", bus.mul_go, 32'd1);
    chk("mh_run_retry_stall", bus.stall, 32'h07);
    tick();
    bus.dmem_req_m = 0; bus.dmem_ack = 0; bus.mul_busy = 0;
    tick();
    clear_in();

    // watchdog: 8 busy MUL_WAIT cycles abort
    bus.mul_start_e = 1;
    #1;
    chk("wd_go", bus.mul_go, 32'd1);
    tick();
    bus.mul_busy = 1;
    for (int i = 1; i <= 7; i++) begin
      #1;
      chk("wd_wait_stall", bus.stall, 32'h07);
      chk("wd_wait_to", bus.mul_timeout, 32'd0);
      tick();
    end
    #1;
    chk("wd_abort_flush2", bus.flush[2], 32'd1);
    chk("wd_abort_stall2", bus.stall[2], 32'd0);
    chk("wd_abort_to", bus.mul_timeout, 32'd0);
    tick();
    bus.mul_start_e = 0;
    #1;
    chk("wd_to_set", bus.mul_timeout, 32'd1);
    chk("wd_run_stall", bus.stall, 32'h00);
    bus.mul_busy = 0;
    tick();
    tick();
    tick();
    chk("wd_to_sticky", bus.mul_timeout, 32'd1);
    clear_in();

    // reset mid-MUL_WAIT
    bus.mul_start_e = 1;
    tick();
    bus.mul_busy = 1;
    #1;
    chk("rw_wait_stall", bus.stall, 32'h07);
    chk("rw_wait_go", bus.mul_go, 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_rst_stall", bus.stall, 32'h00);
    chk("rw_rst_flush", bus.flush, 32'h1f);
    chk("rw_rst_go", bus.mul_go, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rw_run_go", bus.mul_go, 32'd1);
    chk("rw_to_clr", bus.mul_timeout, 32'd0);
    chk("rw_scnt", bus.stall_cycles, 32'd0);
    chk("rw_fcnt", bus.flush_events, 32'd0);
    tick();
    clear_in();
    tick();

`ifndef PIPE_PERF_CNT_EN
    chk("cnt_tied_s", bus.stall_cycles, 32'd0);
    chk("cnt_tied_f", bus.flush_events, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
